// File: rtl/sdm_req_gen.sv
// sdm_req_gen: per-input-port YX route computation and 4-phase request/grant
// handshake toward the switch allocator, one independent FSM per virtual circuit.
module sdm_req_gen #(
   parameter int  VCN  = 2,
   parameter int  AW   = 4,
   parameter int  PORT = 4,
   localparam int DIRN = (PORT == 1 || PORT == 3) ? 2 : 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [AW-1:0]       loc_x_i,
   input  logic [AW-1:0]       loc_y_i,
   input  logic [VCN-1:0]      hd_vld_i,
   input  logic [VCN*2*AW-1:0] hd_dst_i,
   output logic [VCN-1:0]      hd_rdy_o,
   input  logic [VCN-1:0]      tail_i,
   output logic [VCN*DIRN-1:0] req_o,
   input  logic [VCN-1:0]      ack_i,
   output logic [VCN-1:0]      grant_o,
   output logic                err_o
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACT, S_REL} state_e;
   // direction codes equal the port identities so the maps below stay short
   localparam logic [2:0] D_S = 3'd0, D_W = 3'd1, D_N = 3'd2, D_E = 3'd3, D_L = 3'd4, NONE = 3'd7;
   function automatic logic [4:0] route(input logic [AW-1:0] dy, dx, ly, lx);
      logic [2:0] d, idx;
      d = (dy > ly) ? D_N : (dy < ly) ? D_S : (dx > lx) ? D_E : (dx < lx) ? D_W : D_L;
      case (PORT)
         0:       idx = (d == D_S) ? NONE : d - 3'd1;
         1:       idx = (d == D_E) ? 3'd0 : (d == D_L) ? 3'd1 : NONE;
         2:       idx = (d == D_N) ? NONE : (d == D_E) ? 3'd2 : (d == D_L) ? 3'd3 : d;
         3:       idx = (d == D_W) ? 3'd0 : (d == D_L) ? 3'd1 : NONE;
         default: idx = (d == D_L) ? NONE : d;
      endcase
      return {idx != NONE, (idx < 3'd4) ? 4'b0001 << idx[1:0] : 4'b0000};
   endfunction
   logic [4:0]          rt [VCN];
   state_e              st_q [VCN], st_d [VCN];
   logic [VCN*DIRN-1:0] req_q, req_d;
   logic [VCN-1:0]      rdy_q, rdy_d, ack_m_q, ack_s_q;
   logic                err_q, err_d;
   for (genvar i = 0; i < VCN; i++) begin : g_vc
      assign rt[i] = route(hd_dst_i[i*2*AW+AW +: AW], hd_dst_i[i*2*AW +: AW], loc_y_i, loc_x_i);
      assign grant_o[i] = (st_q[i] == S_ACT);
   end
   assign hd_rdy_o = rdy_q;
   assign req_o    = req_q;
   assign err_o    = err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < VCN; i++) st_q[i] <= S_IDLE;
         req_q   <= '0;
         rdy_q   <= '0;
         err_q   <= 1'b0;
         ack_m_q <= '0;
         ack_s_q <= '0;
      end else begin
         st_q    <= st_d;
         req_q   <= req_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         ack_m_q <= ack_i;
         ack_s_q <= ack_m_q;
      end
   end
   // a head still showing its hd_rdy pulse is the one just consumed, not a new one
   always_comb begin
      st_d  = st_q;
      req_d = req_q;
      rdy_d = '0;
      err_d = err_q;
      for (int i = 0; i < VCN; i++) begin
         case (st_q[i])
            S_IDLE: if (hd_vld_i[i] && !rdy_q[i]) begin
               rdy_d[i] = 1'b1;
               err_d    = err_d | ~rt[i][4];
               if (rt[i][4]) begin
                  req_d[i*DIRN +: DIRN] = rt[i][DIRN-1:0];
                  st_d[i]               = S_REQ;
               end
            end
            S_REQ: begin
               err_d = err_d | tail_i[i];
               if (ack_s_q[i]) st_d[i] = S_ACT;
            end
            S_ACT: if (tail_i[i]) begin
               req_d[i*DIRN +: DIRN] = '0;
               st_d[i]               = S_REL;
            end else if (!ack_s_q[i]) err_d = 1'b1;
            default: if (!ack_s_q[i]) st_d[i] = S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/sdm_req_gen.md
Name: sdm_req_gen

Overview:
- Per-input-port request generator on the input-buffer side of the SDM switch allocator.
- Each virtual circuit (VC) presents a head flit's destination. The block computes a YX route and drives a one-hot output-port request to the allocator.
- It holds the request until the allocator acknowledges, keeps the VC granted until the tail flit leaves, then completes the 4-phase return-to-zero handshake.
- It is clocked, and the allocator acks are synchronised inside the block.

Parameters:
- VCN, 2, number of virtual circuits on this input port.
- AW, 4, width of each coordinate (x, y).
- PORT, 4, input port identity: 0=S, 1=W, 2=N, 3=E, 4=L.
- DIRN, derived: 2 when PORT is 1 or 3, otherwise 4. Number of output-direction request bits per VC.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- loc_x  in  AW  this router's x coordinate (quasi-static).
- loc_y  in  AW  this router's y coordinate (quasi-static).
- hd_vld  in  VCN  head flit valid per VC; held until hd_rdy.
- hd_dst  in  VCN*2*AW  per VC: {dst_y, dst_x}.
- hd_rdy  out  VCN  one-cycle pulse: head route accepted.
- tail  in  VCN  one-cycle pulse: tail flit of the VC has passed the crossbar.
- req  out  VCN*DIRN  one-hot request per VC to the allocator (req[i][d]).
- ack  in  VCN  allocator ack per VC; asynchronous to clk.
- grant  out  VCN  VC holds an output channel, data may flow.
- err  out  1  sticky protocol/route error flag.

Behaviour:
- Reset (async assert, sync-released by the surrounding system): all VC FSMs go to IDLE. req=0, hd_rdy=0, grant=0, err=0, sync flops=0. Reset mid-operation drops req immediately, with no handshake completion.
- ack synchroniser: 2 flops per VC producing ack_s. Latency from ack edge to ack_s is 2 clocks.
- Route (YX, combinational on hd_dst):
  - dst_y>loc_y gives N; dst_y<loc_y gives S.
  - Otherwise dst_x>loc_x gives E; dst_x<loc_x gives W.
  - Otherwise L.
  - Comparisons are unsigned, AW bits.
- Direction-to-bit map:
  - PORT0 (S): [0]W [1]N [2]E [3]L.
  - PORT1 (W): [0]E [1]L.
  - PORT2 (N): [0]S [1]W [2]E [3]L.
  - PORT3 (E): [0]W [1]L.
  - PORT4 (L): [0]S [1]W [2]N [3]E.
  - Any direction absent from the port's map is illegal: S from S, N from N, L from L, and for W/E ports any Y move or a reverse X move.
- Per-VC FSM, states IDLE, REQ, ACT, REL:
  - IDLE: on edge with hd_vld=1 and a legal route, register the one-hot into req and go to REQ. hd_rdy is high for the following cycle.
  - IDLE with an illegal route: hd_rdy pulses, req stays 0, err=1, stay in IDLE. The buffer drops the packet.
  - REQ: req held stable; hd_vld ignored. When ack_s=1, go to ACT. tail=1 in REQ sets err and is otherwise ignored.
  - ACT: grant=1. When tail=1, clear req and grant and go to REL. ack_s falling in ACT sets err; the VC stays in ACT.
  - REL: wait for ack_s=0, then go to IDLE. A new head is accepted no earlier than the edge after IDLE is re-entered.
- Latencies:
  - hd_vld sampled at edge k gives req high after edge k.
  - ack rising before edge k gives grant high after edge k+2.
  - tail at edge m gives req and grant low after edge m.
- VCs are fully independent. Simultaneous events on different VCs are handled in parallel with no priority.
- req never has more than one bit set per VC.
- req for a VC never changes while the VC is in REQ or ACT.
- err clears only on reset.

Test Plan:
- PORT=4, loc=(2,2), VC0 hd_dst y=5 x=2 → req[0]=4'b0100 one cycle after acceptance. ack[0]↑ → grant[0]=1 three edges later. tail[0] → req[0]=0, grant[0]=0 next cycle. ack[0]↓ → IDLE, then next head accepted.
- PORT=4, VC0 dst (2,0) W and VC1 dst (2,3) E in the same cycle → req[0]=0010 and req[1]=1000 concurrently. Acks in reverse order give independent grants.
- PORT=1, dst y=3 (Y move) → hd_rdy pulse, req=00, err=1 and it stays 1. PORT=1, dst (2,5) → req=01 (E).
- PORT=4, dst (2,2) (L to L) → err=1, no req. PORT=0, dst y=2 x=2 → req=1000 (L).
- tail pulsed in REQ → err=1, req unchanged. ack dropped in ACT → err=1, grant stays 1.
- rst_n asserted while VC0 is in ACT with ack=1 → req, grant, err go to 0 asynchronously. After release with ack still 1 and a new head presented, req asserts; grant follows 2 edges later from the synchroniser.
